dot_pipe_scheduler: RTL and testbench
=====================================

// Module: dot_pipe_scheduler
// PURPOSE
//  Shares one fixed-latency dot-product pipeline (10-lane, 32b) between NREQ requesters.
//  - Round-robin arbitration; tag tracking of in-flight operations.
//  - Credit-based result FIFO, so the non-stallable pipeline never loses a result.
//  - Sits between the requester operand muxes and the dot engine; drives the engine's operand select.
// PARAMETERS
//  NREQ   4   number of requesters (2..8)
//  TAGW   2   requester tag width, = clog2(NREQ)
//  LAT    6   engine latency: operand-capture edge to valid result, in cycles
//  DEPTH  8   result FIFO entries; must be >= LAT; also the credit pool size
// PORTS
//  clk        in   1          clock, rising edge
//  rst_n      in   1          asynchronous active-low reset
//  req_valid  in   NREQ       per-requester operation request
//  req_ready  out  NREQ       one-hot grant; a transfer occurs when req_valid[i]&req_ready[i]
//  dp_sel     out  TAGW       engine operand-mux select (index of the granted requester)
//  dp_issue   out  1          engine captures operands at the end of this cycle
//  dp_result  in   53         engine output; result value = dp_result[32:1]
//  rsp_valid  out  1          result available at the FIFO head
//  rsp_ready  in   1          consumer accepts the head result
//  rsp_tag    out  TAGW       requester index of the head result
//  rsp_data   out  32         head result, two's-complement sum mod 2^32
// BEHAVIOUR
//  Reset values: req_ready=0, dp_issue=0, dp_sel=0, rsp_valid=0, rsp_tag=0, rsp_data=0.
//  Reset internals: rr_ptr=0, credits=DEPTH, tag pipe valids=0, FIFO empty.
//  Arbitration (combinational):
//  - When credits>0, grant the first requester with req_valid set, searching from rr_ptr upward with wrap.
//  - When credits==0, req_ready=0.
//  - dp_issue = |(req_valid&req_ready); dp_sel = index of the granted requester.
//  - On issue, rr_ptr <= granted index + 1 (mod NREQ). With no issue, rr_ptr holds.
//  Tag pipe:
//  - LAT-deep shift register of {vld,tag}, advancing every cycle.
//  - Entry 0 is loaded with {dp_issue,dp_sel}.
//  - When the last stage is valid, {tag, dp_result[32:1]} is pushed into the FIFO that same cycle.
//  Latency: issue in cycle t -> FIFO push at the end of cycle t+LAT -> rsp_valid earliest in cycle t+LAT+1.
//  Credits:
//  - Decrement on issue; increment on pop (rsp_valid&rsp_ready).
//  - Simultaneous issue and pop: no change.
//  - Invariant: credits + in-flight + FIFO occupancy == DEPTH, so a push never meets a full FIFO.
//  FIFO:
//  - Circular buffer; read and write pointers wrap at DEPTH.
//  - rsp_* are registered from the head entry (first-word fall-through).
//  - Push and pop in the same cycle are both performed; occupancy is unchanged.
//  - Push into an empty FIFO: rsp_valid rises in the next cycle.
//  - Pop when empty is impossible, because rsp_valid=0.
//  Ordering: results return in issue order. Back-to-back issue gives one result per cycle.
//  Reset mid-operation:
//  - All in-flight tags and FIFO contents are dropped; credits return to DEPTH.
//  - Engine contents are unreset but ignored, because all vld bits are 0.
//  A requester may drop req_valid before it is granted; no state is affected.
// CONFIGURATION
//  DOT_SCHED_PERF_EN defined:
//  - Adds outputs perf_issues[31:0] (count of issues) and perf_stalls[31:0]
//    (cycles with |req_valid & credits==0).
//  - Both are reset to 0 and saturate at 2^32-1.
//  DOT_SCHED_PERF_EN undefined: these ports and counters do not exist; all other behaviour is identical.
// TESTING
//  1. Single op: req_valid=4'b0010 for 1 cycle, engine model returns 0x0000_0064.
//     -> rsp_valid in cycle t+7, rsp_tag=1, rsp_data=0x64.
//  2. All 4 requesting continuously, rsp_ready=1.
//     -> grants 0,1,2,3,0,... one per cycle; rsp_tag sequence matches the grant order.
//  3. rsp_ready=0, all requesting.
//     -> exactly 8 issues, then req_ready=0; credits=0.
//     -> Raise rsp_ready for 1 cycle -> exactly one further issue.
//  4. Simultaneous issue and pop with FIFO at 7 entries.
//     -> occupancy stays 7; credits unchanged; no result lost.
//  5. rst_n low for 1 cycle with 3 ops in flight.
//     -> no rsp_valid is ever produced for them; credits=8; rr_ptr=0.
//  6. With DOT_SCHED_PERF_EN: scenario 3 run for 20 cycles.
//     -> perf_issues=8, perf_stalls=12.

Source files
------------

// File: rtl/dot_pipe_scheduler_if.sv
// Handshake/bus bundle between requesters, the dot engine and the result consumer.
// slave  : the scheduler side.
// master : the environment side (requesters, engine, consumer).
interface dot_pipe_scheduler_if #(
  parameter int NREQ = 4,
  parameter int TAGW = 2
);
  logic [NREQ-1:0] req_valid;
  logic [NREQ-1:0] req_ready;
  logic [TAGW-1:0] dp_sel;
  logic            dp_issue;
  logic [52:0]     dp_result;
  logic            rsp_valid;
  logic            rsp_ready;
  logic [TAGW-1:0] rsp_tag;
  logic [31:0]     rsp_data;

  modport slave (
    input  req_valid, dp_result, rsp_ready,
    output req_ready, dp_sel, dp_issue, rsp_valid, rsp_tag, rsp_data
  );

  modport master (
    output req_valid, dp_result, rsp_ready,
    input  req_ready, dp_sel, dp_issue, rsp_valid, rsp_tag, rsp_data
  );
endinterface

// File: rtl/dot_pipe_scheduler.sv
// dot_pipe_scheduler: shares one fixed-latency, non-stallable dot-product engine
// between NREQ requesters. Round-robin grant, a tag pipe that follows each
// operation through the engine, and a credit-guarded result FIFO so a result
// arriving from the engine always has a slot.
// Optional macro DOT_SCHED_PERF_EN adds perf_issues / perf_stalls counters.
module dot_pipe_scheduler #(
  parameter int NREQ  = 4,
  parameter int TAGW  = 2,
  parameter int LAT   = 6,
  parameter int DEPTH = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  dot_pipe_scheduler_if.slave  bus
`ifdef DOT_SCHED_PERF_EN
  ,
  output logic [31:0]          perf_issues,
  output logic [31:0]          perf_stalls
`endif
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef struct packed {
    logic [TAGW-1:0] tag;
    logic [31:0]     data;
  } rsp_t;

  logic [TAGW-1:0]           r_rr_ptr;
  logic [CW-1:0]             r_credits;
  logic [LAT-1:0]            r_vld_pipe;
  logic [LAT-1:0][TAGW-1:0]  r_tag_pipe;
  rsp_t                      r_mem [DEPTH];
  logic [PW-1:0]             r_wptr, r_rptr;
  logic [CW-1:0]             r_count;
  logic                      r_rsp_valid;
  rsp_t                      r_rsp;

  logic [NREQ-1:0]           w_grant;
  logic [TAGW-1:0]           w_sel;
  logic                      w_found;
  logic                      w_issue;
  logic                      w_push, w_pop, w_bypass;
  rsp_t                      w_push_ent, w_head_nxt;
  logic [CW-1:0]             w_cnt_nxt;
  logic [PW-1:0]             w_rptr_nxt;
  logic                      w_unused_dp;

  function automatic logic [PW-1:0] f_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Round-robin search from r_rr_ptr with wrap; no grant while the credit pool is empty.
  always_comb begin
    int idx;
    idx     = 0;
    w_grant = '0;
    w_sel   = '0;
    w_found = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      idx = (int'(r_rr_ptr) + k) % NREQ;
      if (!w_found && bus.req_valid[idx]) begin
        w_found = 1'b1;
        w_sel   = TAGW'(idx);
      end
    end
    if (w_found && (r_credits != '0)) w_grant[w_sel] = 1'b1;
  end

  assign w_issue       = |(bus.req_valid & w_grant);
  assign bus.req_ready = w_grant;
  assign bus.dp_issue  = w_issue;
  assign bus.dp_sel    = w_issue ? w_sel : '0;

  // Only the 32b result field of the engine word is meaningful.
  assign w_unused_dp = ^{bus.dp_result[52:33], bus.dp_result[0]};

  // Arbitration pointer moves past the winner only when an operation is issued.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       r_rr_ptr <= '0;
    else if (w_issue) r_rr_ptr <= (w_sel == TAGW'(NREQ - 1)) ? '0 : w_sel + 1'b1;
  end

  // Tag pipe mirrors the engine: the last stage lines up with dp_result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vld_pipe <= '0;
      r_tag_pipe <= '0;
    end else begin
      r_vld_pipe[0] <= w_issue;
      r_tag_pipe[0] <= w_sel;
      for (int k = 1; k < LAT; k++) begin
        r_vld_pipe[k] <= r_vld_pipe[k-1];
        r_tag_pipe[k] <= r_tag_pipe[k-1];
      end
    end
  end

  assign w_push          = r_vld_pipe[LAT-1];
  assign w_pop           = r_rsp_valid & bus.rsp_ready;
  assign w_push_ent.tag  = r_tag_pipe[LAT-1];
  assign w_push_ent.data = bus.dp_result[32:1];

  // Credits: one per FIFO slot not yet claimed by an in-flight or stored result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_credits <= CW'(DEPTH);
    else begin
      case ({w_issue, w_pop})
        2'b10:   r_credits <= r_credits - 1'b1;
        2'b01:   r_credits <= r_credits + 1'b1;
        default: r_credits <= r_credits;
      endcase
    end
  end

  // Next FIFO state and next head entry; a push into a FIFO that is empty
  // after this cycle's pop bypasses storage straight to the head register.
  always_comb begin
    w_cnt_nxt = r_count;
    if (w_push && !w_pop)      w_cnt_nxt = r_count + 1'b1;
    else if (!w_push && w_pop) w_cnt_nxt = r_count - 1'b1;
    w_rptr_nxt = w_pop ? f_inc(r_rptr) : r_rptr;
    w_bypass   = w_push && (r_count == CW'(w_pop));
    w_head_nxt = w_bypass ? w_push_ent : r_mem[w_rptr_nxt];
  end

  // Result storage; contents are don't-care until covered by r_count.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= w_push_ent;
  end

  // FIFO pointers, occupancy and registered head (first-word fall-through).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr      <= '0;
      r_rptr      <= '0;
      r_count     <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp       <= '0;
    end else begin
      if (w_push) r_wptr <= f_inc(r_wptr);
      r_rptr      <= w_rptr_nxt;
      r_count     <= w_cnt_nxt;
      r_rsp_valid <= (w_cnt_nxt != '0);
      if (w_cnt_nxt != '0) r_rsp <= w_head_nxt;
    end
  end

  assign bus.rsp_valid = r_rsp_valid;
  assign bus.rsp_tag   = r_rsp.tag;
  assign bus.rsp_data  = r_rsp.data;

`ifdef DOT_SCHED_PERF_EN
  // Saturating issue / credit-stall counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_issues <= '0;
      perf_stalls <= '0;
    end else begin
      if (w_issue && (perf_issues != '1)) perf_issues <= perf_issues + 1'b1;
      if ((|bus.req_valid) && (r_credits == '0) && (perf_stalls != '1))
        perf_stalls <= perf_stalls + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_dot_pipe_scheduler.sv
// Self-checking bench for dot_pipe_scheduler (NREQ=4, LAT=6, DEPTH=8).
// Scoreboard: expected {tag,data} queued at issue, compared at pop.
module tb_dot_pipe_scheduler;
  localparam int NREQ = 4, TAGW = 2, LAT = 6, DEPTH = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  dot_pipe_scheduler_if #(.NREQ(NREQ), .TAGW(TAGW)) bus();

`ifdef DOT_SCHED_PERF_EN
  logic [31:0] perf_issues, perf_stalls;
`endif

  dot_pipe_scheduler #(.NREQ(NREQ), .TAGW(TAGW), .LAT(LAT), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
`ifdef DOT_SCHED_PERF_EN
    , .perf_issues(perf_issues), .perf_stalls(perf_stalls)
`endif
  );

  int n_checks = 0;
  int n_fail   = 0;
  int issue_cnt = 0;
  logic        use_fixed = 1'b0;
  logic [31:0] fixed_val = '0;
  logic [33:0] exp_q[$];

  // Engine model: LAT-deep pipeline, result field at [32:1], junk elsewhere.
  logic [52:0] eng [LAT];
  logic [52:0] eng_nxt = '0;
  assign bus.dp_result = eng[LAT-1];

  always @(posedge clk) begin
    eng[0] <= eng_nxt;
    for (int k = 1; k < LAT; k++) eng[k] <= eng[k-1];
  end

  // Monitor: record issues into scoreboard, check popped results.
  always @(negedge clk) begin
    logic [31:0] v;
    logic [33:0] e;
    if (!rst_n) begin
      exp_q.delete();
      eng_nxt <= 53'({$urandom(), $urandom()});
    end else begin
      if (bus.dp_issue) begin
        v = use_fixed ? fixed_val : $urandom();
        exp_q.push_back({bus.dp_sel, v});
        eng_nxt <= {20'($urandom()), v, 1'($urandom())};
        issue_cnt++;
      end else begin
        eng_nxt <= 53'({$urandom(), $urandom()});
      end
      if (bus.rsp_valid && bus.rsp_ready) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL scoreboard_unexpected: got tag=%0d data=%h, required no result", bus.rsp_tag, bus.rsp_data);
        end else begin
          e = exp_q.pop_front();
          if ({bus.rsp_tag, bus.rsp_data} !== e) begin
            n_fail++;
            $display("FAIL scoreboard: got tag=%0d data=%h, required tag=%0d data=%h",
                     bus.rsp_tag, bus.rsp_data, e[33:32], e[31:0]);
          end
        end
      end
    end
  end

  task automatic do_reset;
    @(posedge clk); #1;
    bus.req_valid = '0; bus.rsp_ready = 1'b0; rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic drain;
    logic done;
    done = 1'b0;
    bus.rsp_ready = 1'b1;
    for (int c = 0; c < 60 && !done; c++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && !bus.rsp_valid) done = 1'b1;
    end
    n_checks++;
    if (!done) begin
      n_fail++;
      $display("FAIL drain_timeout: got %0d outstanding, required 0", exp_q.size());
    end
    @(posedge clk); #1;
    bus.rsp_ready = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; bus.req_valid = '0; bus.rsp_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_checks += 6;
    if (bus.req_ready !== 4'b0) begin n_fail++; $display("FAIL rst_req_ready: got %b, required 0", bus.req_ready); end
    if (bus.dp_issue !== 1'b0)  begin n_fail++; $display("FAIL rst_dp_issue: got %b, required 0", bus.dp_issue); end
    if (bus.dp_sel !== 2'd0)    begin n_fail++; $display("FAIL rst_dp_sel: got %0d, required 0", bus.dp_sel); end
    if (bus.rsp_valid !== 1'b0) begin n_fail++; $display("FAIL rst_rsp_valid: got %b, required 0", bus.rsp_valid); end
    if (bus.rsp_tag !== 2'd0)   begin n_fail++; $display("FAIL rst_rsp_tag: got %0d, required 0", bus.rsp_tag); end
    if (bus.rsp_data !== 32'd0) begin n_fail++; $display("FAIL rst_rsp_data: got %h, required 0", bus.rsp_data); end
`ifdef DOT_SCHED_PERF_EN
    n_checks++;
    if (perf_issues !== 32'd0 || perf_stalls !== 32'd0) begin
      n_fail++; $display("FAIL rst_perf: got %0d/%0d, required 0/0", perf_issues, perf_stalls);
    end
`endif
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    n_checks += 2;
    if (dut.r_credits !== 4'd8) begin n_fail++; $display("FAIL rst_credits: got %0d, required 8", dut.r_credits); end
    if (dut.r_rr_ptr !== 2'd0)  begin n_fail++; $display("FAIL rst_rr_ptr: got %0d, required 0", dut.r_rr_ptr); end
  endtask

  task automatic test_single_op;
    @(posedge clk); #1;
    use_fixed = 1'b1; fixed_val = 32'h0000_0064;
    bus.req_valid = 4'b0010;
    @(negedge clk);
    n_checks += 2;
    if (bus.dp_issue !== 1'b1) begin n_fail++; $display("FAIL single_issue: got %b, required 1", bus.dp_issue); end
    if (bus.dp_sel !== 2'd1)   begin n_fail++; $display("FAIL single_sel: got %0d, required 1", bus.dp_sel); end
    @(posedge clk); #1;
    bus.req_valid = '0; use_fixed = 1'b0;
    for (int k = 1; k <= LAT + 1; k++) begin
      @(negedge clk);
      n_checks++;
      if (k <= LAT) begin
        if (bus.rsp_valid !== 1'b0) begin n_fail++; $display("FAIL single_early_valid: cycle t+%0d got 1, required 0", k); end
      end else begin
        if (bus.rsp_valid !== 1'b1) begin n_fail++; $display("FAIL single_valid: cycle t+%0d got %b, required 1", k, bus.rsp_valid); end
        n_checks += 2;
        if (bus.rsp_tag !== 2'd1)         begin n_fail++; $display("FAIL single_tag: got %0d, required 1", bus.rsp_tag); end
        if (bus.rsp_data !== 32'h64)      begin n_fail++; $display("FAIL single_data: got %h, required 64", bus.rsp_data); end
      end
    end
    @(posedge clk); #1;
    drain();
  endtask

  task automatic test_round_robin;
    logic [1:0] es;
    do_reset();
    bus.rsp_ready = 1'b1;
    bus.req_valid = 4'hF;
    for (int n = 0; n < 16; n++) begin
      @(negedge clk);
      es = 2'(n % 4);
      n_checks += 2;
      if (bus.dp_sel !== es) begin n_fail++; $display("FAIL rr_sel: n=%0d got %0d, required %0d", n, bus.dp_sel, es); end
      if (bus.req_ready !== (4'b0001 << es)) begin
        n_fail++; $display("FAIL rr_ready: n=%0d got %b, required %b", n, bus.req_ready, 4'b0001 << es);
      end
    end
    @(posedge clk); #1;
    bus.req_valid = '0;
    drain();
  endtask

  task automatic test_rr_skip;
    logic [1:0] es;
    do_reset();
    bus.rsp_ready = 1'b1;
    bus.req_valid = 4'b1010;
    for (int n = 0; n < 4; n++) begin
      @(negedge clk);
      es = (n % 2 == 0) ? 2'd1 : 2'd3;
      n_checks++;
      if (bus.dp_sel !== es) begin n_fail++; $display("FAIL skip_sel: n=%0d got %0d, required %0d", n, bus.dp_sel, es); end
    end
    @(posedge clk); #1;
    bus.req_valid = '0;
    drain();
  endtask

  task automatic test_credit_stall;
    int c0;
    do_reset();
    bus.req_valid = 4'hF;
    c0 = issue_cnt;
    repeat (20) @(posedge clk);
    #1;
    n_checks += 3;
    if (issue_cnt - c0 != 8) begin n_fail++; $display("FAIL stall_issues: got %0d, required 8", issue_cnt - c0); end
    if (bus.req_ready !== 4'b0) begin n_fail++; $display("FAIL stall_ready: got %b, required 0", bus.req_ready); end
    if (dut.r_credits !== 4'd0) begin n_fail++; $display("FAIL stall_credits: got %0d, required 0", dut.r_credits); end
`ifdef DOT_SCHED_PERF_EN
    n_checks += 2;
    if (perf_issues !== 32'd8)  begin n_fail++; $display("FAIL perf_issues: got %0d, required 8", perf_issues); end
    if (perf_stalls !== 32'd12) begin n_fail++; $display("FAIL perf_stalls: got %0d, required 12", perf_stalls); end
`endif
    bus.rsp_ready = 1'b1;
    @(posedge clk); #1;
    bus.rsp_ready = 1'b0;
    c0 = issue_cnt;
    repeat (5) @(posedge clk);
    #1;
    n_checks++;
    if (issue_cnt - c0 != 1) begin n_fail++; $display("FAIL stall_one_more: got %0d, required 1", issue_cnt - c0); end
    bus.req_valid = '0;
    drain();
  endtask

  task automatic test_push_pop_full;
    do_reset();
    @(posedge clk); #1;
    bus.req_valid = 4'b0100;
    repeat (8) @(posedge clk);
    #1;
    bus.req_valid = '0;
    repeat (5) @(posedge clk);
    #1;
    n_checks += 2;
    if (dut.r_count !== 4'd7)   begin n_fail++; $display("FAIL pp_pre_count: got %0d, required 7", dut.r_count); end
    if (dut.r_credits !== 4'd0) begin n_fail++; $display("FAIL pp_pre_credits: got %0d, required 0", dut.r_credits); end
    bus.rsp_ready = 1'b1;
    @(posedge clk); #1;
    n_checks += 2;
    if (dut.r_count !== 4'd7)   begin n_fail++; $display("FAIL pp_count: got %0d, required 7", dut.r_count); end
    if (dut.r_credits !== 4'd1) begin n_fail++; $display("FAIL pp_credits: got %0d, required 1", dut.r_credits); end
    bus.req_valid = 4'b0001;
    @(negedge clk);
    n_checks++;
    if (bus.dp_issue !== 1'b1) begin n_fail++; $display("FAIL pp_issue: got %b, required 1", bus.dp_issue); end
    @(posedge clk); #1;
    n_checks += 2;
    if (dut.r_credits !== 4'd1) begin n_fail++; $display("FAIL ip_credits: got %0d, required 1", dut.r_credits); end
    if (dut.r_count !== 4'd6)   begin n_fail++; $display("FAIL ip_count: got %0d, required 6", dut.r_count); end
    bus.req_valid = '0;
    drain();
  endtask

  task automatic test_reset_inflight;
    int c0, seen;
    c0 = issue_cnt;
    @(posedge clk); #1;
    bus.req_valid = 4'b0111;
    repeat (3) @(posedge clk);
    #1;
    bus.req_valid = '0;
    n_checks++;
    if (issue_cnt - c0 != 3) begin n_fail++; $display("FAIL rif_issues: got %0d, required 3", issue_cnt - c0); end
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    n_checks += 2;
    if (dut.r_credits !== 4'd8) begin n_fail++; $display("FAIL rif_credits: got %0d, required 8", dut.r_credits); end
    if (dut.r_rr_ptr !== 2'd0)  begin n_fail++; $display("FAIL rif_rr_ptr: got %0d, required 0", dut.r_rr_ptr); end
    bus.rsp_ready = 1'b1;
    seen = 0;
    repeat (12) begin
      @(negedge clk);
      if (bus.rsp_valid) seen++;
    end
    n_checks++;
    if (seen != 0) begin n_fail++; $display("FAIL rif_rsp_valid: got %0d valid cycles, required 0", seen); end
    bus.rsp_ready = 1'b0;
  endtask

  initial begin
    bus.req_valid = '0;
    bus.rsp_ready = 1'b0;
    test_reset();
    test_single_op();
    test_round_robin();
    test_rr_skip();
    test_credit_stall();
    test_push_pop_full();
    test_reset_inflight();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog");
  end
endmodule
